ad_ip_jesd204_tpl_adc_pn_mon: RTL and testbench
===============================================

// Module: ad_ip_jesd204_tpl_adc_pn_mon
//
// PURPOSE
// Multi-channel PN-sequence error monitor for the JESD204 TPL ADC datapath.
// Counts per-channel PN errors over a software-programmed window and latches sticky per-channel OOS flags.
// Exposes results through a local up-style register port that is OR-combined with the existing channel register banks.
// Sits in the adc_clk domain, beside the per-channel PN checkers that drive pn_err/pn_oos.
//
// PARAMETERS
// NUM_CHANNELS  1   monitored channels, 1..64
// CNT_WIDTH     32  per-channel error counter width, 8..32; zero-extended to 32 on read
// WINDOW_WIDTH  32  window length counter width, 1..32
//
// PORTS
// adc_clk     in   1               clock (single clock domain)
// adc_rst     in   1               reset, synchronous, active-high
// enable      in   NUM_CHANNELS    channel enable; disabled channels never count
// pn_err      in   NUM_CHANNELS    per-channel PN mismatch, 1 per cycle
// pn_oos      in   NUM_CHANNELS    per-channel PN out-of-sync
// up_wreq     in   1               write request, 1-cycle pulse
// up_waddr    in   8               word address
// up_wdata    in   32              write data
// up_wack     out  1               write ack
// up_rreq     in   1               read request, 1-cycle pulse
// up_raddr    in   8               word address
// up_rdata    out  32              read data; 0 when up_rack=0
// up_rack     out  1               read ack
// irq         out  1               interrupt; present only with PN_MON_IRQ_EN, else tied 0
//
// BEHAVIOUR
// - Register map (word addr):
//   - 0x00 CTRL: [0] START (W1, self-clearing); [1] CLEAR (W1, self-clearing). Reads 0.
//   - 0x01 WINDOW RW: window length in cycles, reset 0.
//   - 0x02 STATUS: [0] BUSY RO; [1] DONE W1C; [2] ANY_OOS RO (OR of sticky bits).
//   - 0x03 REMAIN RO: cycles left in current window.
//   - 0x04 IRQ_MASK: see CONFIGURATION.
//   - 0x08, 0x09 OOS_STICKY W1C: bit i = channel 32*(addr-8)+i. Bits >= NUM_CHANNELS read 0.
//   - 0x10+i ERRCNT[i] RO, i < NUM_CHANNELS.
// - Decode: ack only for mapped addresses (0x00-0x04, 0x08 and 0x09 if NUM_CHANNELS>32, 0x10..0x10+NUM_CHANNELS-1). Unmapped addresses: no ack, rdata 0.
// - Handshake: up_wack/up_rack assert exactly 1 cycle after the request, for 1 cycle. up_rdata is registered and valid with up_rack.
// - Input pipeline: pn_err/pn_oos/enable are registered once. An error in cycle N is visible in ERRCNT at cycle N+2.
// - FSM:
//   - IDLE -> ARM on START.
//   - ARM (1 cycle): counters cleared, REMAIN<=WINDOW -> RUN.
//   - RUN: counters increment; REMAIN decrements per cycle; REMAIN==0 -> DONE-state.
//   - DONE-state (1 cycle): sets DONE -> IDLE.
//   - BUSY=1 in ARM and RUN.
// - START while in RUN: restart via ARM. The current window is discarded; DONE is not set.
// - WINDOW=0: ARM -> RUN -> DONE-state. No counting; DONE sets 3 cycles after the START write.
// - Counting: ERRCNT[i]++ in RUN iff registered pn_err[i] & enable[i] & ~pn_oos[i]. Saturates at 2^CNT_WIDTH-1 (no wrap).
// - OOS sticky bit i sets whenever registered pn_oos[i] & enable[i], in any FSM state.
// - CLEAR: zeroes all ERRCNT and OOS_STICKY; FSM state is unchanged.
// - Simultaneous events: clear beats increment; set beats W1C (DONE, OOS_STICKY); START beats CLEAR on FSM.
// - adc_rst: all registers, counters, sticky bits, FSM(IDLE), up_wack, up_rack, up_rdata=0, irq=0 within 1 cycle. Mid-RUN reset aborts without setting DONE.
//
// CONFIGURATION
// - Macro PN_MON_IRQ_EN.
// - Defined:
//   - IRQ_MASK RW at 0x04, reset 0x3: [0] masks DONE, [1] masks new OOS.
//   - irq is registered: irq <= (DONE & ~m[0]) | (ANY_OOS & ~m[1]).
//   - irq deasserts the cycle after the cause is cleared.
// - Not defined: 0x04 acks, reads 0, writes ignored; irq constant 0; no mask logic synthesised.
//
// TESTING
// - Reset: assert adc_rst mid-RUN with counts nonzero -> next cycle BUSY=0, DONE=0, ERRCNT=0, REMAIN=0, irq=0.
// - Window: NUM_CHANNELS=4, WINDOW=100, pn_err[2]=1 for 10 cycles inside window -> ERRCNT[2]=10, others 0. DONE=1; DONE W1C -> 0.
// - Saturation: CNT_WIDTH=8, pn_err[0]=1 constant, WINDOW=300 -> ERRCNT[0]=255.
// - Gating: pn_oos[1]=1 with pn_err[1]=1 -> ERRCNT[1]=0, OOS_STICKY bit1=1. Write 0x2 to 0x08 while oos low -> bit1=0.
// - Races: CLEAR in the same cycle as a pn_err increment -> 0. START during RUN -> REMAIN reloads to WINDOW and DONE stays 0. Unmapped read at 0x05 -> no up_rack.
// - IRQ (PN_MON_IRQ_EN): IRQ_MASK=0, window completes -> irq=1 one cycle after DONE. W1C DONE -> irq=0. Without the macro, irq stays 0.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_pn_mon.sv
// Windowed per-channel PN error counter with sticky OOS flags and an up-style register port.
// Optional PN_MON_IRQ_EN adds a maskable, registered interrupt and the IRQ_MASK register.
module ad_ip_jesd204_tpl_adc_pn_mon #(
  parameter int NUM_CHANNELS = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int WINDOW_WIDTH = 32
) (
  input  logic                    adc_clk,
  input  logic                    adc_rst,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] pn_err,
  input  logic [NUM_CHANNELS-1:0] pn_oos,
  input  logic                    up_wreq,
  input  logic [7:0]              up_waddr,
  input  logic [31:0]             up_wdata,
  output logic                    up_wack,
  input  logic                    up_rreq,
  input  logic [7:0]              up_raddr,
  output logic [31:0]             up_rdata,
  output logic                    up_rack,
  output logic                    irq
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                   state_q, state_d;
  logic [NUM_CHANNELS-1:0]  err_r, oos_r, en_r;
  logic [NUM_CHANNELS-1:0]  sticky;
  logic [CNT_WIDTH-1:0]     cnt [NUM_CHANNELS];
  logic [WINDOW_WIDTH-1:0]  window, remain;
  logic                     done, set_done, busy, any_oos;
  logic                     start, clear, done_w1c, count_en;
  logic [63:0]              sticky_pad, w1c_vec;
  logic [31:0]              rd_val;
  logic                     unused_bits;

  function automatic logic addr_mapped(input logic [7:0] a);
    return (a <= 8'd4) || (a == 8'd8) || (a == 8'd9 && NUM_CHANNELS > 32) ||
           (a >= 8'd16 && int'(a) < 16 + NUM_CHANNELS);
  endfunction

  assign start    = up_wreq && up_waddr == 8'd0 && up_wdata[0];
  assign clear    = up_wreq && up_waddr == 8'd0 && up_wdata[1];
  assign done_w1c = up_wreq && up_waddr == 8'd2 && up_wdata[1];
  assign busy     = (state_q == S_ARM) || (state_q == S_RUN);
  assign any_oos  = |sticky;
  // The last RUN cycle (remain == 0) only hands over to DONE, so a window of W counts W cycles.
  assign count_en = (state_q == S_RUN) && (remain != '0);

  always_comb begin
    w1c_vec = '0;
    if (up_wreq && up_waddr == 8'd8) w1c_vec[31:0] = up_wdata;
    if (up_wreq && up_waddr == 8'd9 && NUM_CHANNELS > 32) w1c_vec[63:32] = up_wdata;
  end

  always_comb begin
    sticky_pad = '0;
    sticky_pad[NUM_CHANNELS-1:0] = sticky;
  end

  assign unused_bits = ^{w1c_vec, sticky_pad};

  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM:  state_d = start ? S_ARM : S_RUN;
      S_RUN: begin
        if (start) begin
          state_d = S_ARM;
        end else if (remain == '0) begin
          state_d  = S_DONE;
          set_done = 1'b1;
        end
      end
      S_DONE: state_d = start ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q <= S_IDLE;
      err_r   <= '0;
      oos_r   <= '0;
      en_r    <= '0;
      window  <= '0;
      remain  <= '0;
      done    <= 1'b0;
      sticky  <= '0;
    end else begin
      state_q <= state_d;
      err_r   <= pn_err;
      oos_r   <= pn_oos;
      en_r    <= enable;
      if (up_wreq && up_waddr == 8'd1) window <= up_wdata[WINDOW_WIDTH-1:0];
      if (state_q == S_ARM) remain <= window;
      else if (count_en && !start) remain <= remain - 1'b1;
      done   <= (done & ~done_w1c) | set_done;
      // Newly observed OOS wins over both CLEAR and W1C in the same cycle.
      sticky <= (clear ? '0 : (sticky & ~w1c_vec[NUM_CHANNELS-1:0])) | (oos_r & en_r);
    end
  end

  always_ff @(posedge adc_clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (adc_rst || clear || state_q == S_ARM) cnt[i] <= '0;
      else if (count_en && err_r[i] && en_r[i] && !oos_r[i] && cnt[i] != CNT_MAX)
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

`ifdef PN_MON_IRQ_EN
  logic [1:0] irq_mask;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      irq_mask <= 2'b11;
      irq      <= 1'b0;
    end else begin
      if (up_wreq && up_waddr == 8'd4) irq_mask <= up_wdata[1:0];
      irq <= (done & ~irq_mask[0]) | (any_oos & ~irq_mask[1]);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (up_raddr)
      8'd1: rd_val = 32'(window);
      8'd2: rd_val = {29'd0, any_oos, done, busy};
      8'd3: rd_val = 32'(remain);
`ifdef PN_MON_IRQ_EN
      8'd4: rd_val = {30'd0, irq_mask};
`endif
      8'd8: rd_val = sticky_pad[31:0];
      8'd9: rd_val = (NUM_CHANNELS > 32) ? sticky_pad[63:32] : 32'd0;
      default: begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          if (up_raddr == 8'(16 + i)) rd_val = 32'(cnt[i]);
      end
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      up_wack  <= 1'b0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_wack  <= up_wreq && addr_mapped(up_waddr);
      up_rack  <= up_rreq && addr_mapped(up_raddr);
      up_rdata <= (up_rreq && addr_mapped(up_raddr)) ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_mon.sv
// Scoreboarded bench for the PN monitor: register reads queue expectations, a monitor checks them on up_rack.
module tb_ad_ip_jesd204_tpl_adc_pn_mon;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int WW  = 16;

  logic            adc_clk = 1'b0;
  logic            adc_rst = 1'b1;
  logic [NCH-1:0]  enable = '0, pn_err = '0, pn_oos = '0;
  logic            up_wreq = 1'b0, up_rreq = 1'b0;
  logic [7:0]      up_waddr = '0, up_raddr = '0;
  logic [31:0]     up_wdata = '0;
  logic            up_wack, up_rack, irq;
  logic [31:0]     up_rdata;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_t;

  rd_t rq[$];
  int  errors = 0;
  int  checks = 0;
  int  model_cnt[NCH];
  logic [NCH-1:0] model_sticky;

  ad_ip_jesd204_tpl_adc_pn_mon #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(enable), .pn_err(pn_err), .pn_oos(pn_oos),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack), .irq(irq)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge adc_clk) begin
    if (up_rack) begin
      if (rq.size() == 0) begin
        chk("unexpected_rack", {31'd0, up_rack}, 32'd0);
      end else begin
        rd_t r;
        r = rq.pop_front();
        chk($sformatf("rd_%02h", r.addr), up_rdata, r.exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge adc_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge adc_clk); #1;
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    @(posedge adc_clk); #1;
    up_wreq = 1'b0;
    chk($sformatf("wack_%02h", a), {31'd0, up_wack}, 32'd1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    rd_t r;
    r.addr = a; r.exp = exp;
    rq.push_back(r);
    @(posedge adc_clk); #1;
    up_rreq = 1'b1; up_raddr = a;
    @(posedge adc_clk); #1;
    up_rreq = 1'b0;
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > (1 << CW) - 1) ? ((1 << CW) - 1) : v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    adc_rst = 1'b0;
    cyc(1);
    // reset state
    chk("irq_reset", {31'd0, irq}, 32'd0);
    rd(8'h02, 32'h0);
    rd(8'h01, 32'h0);
    rd(8'h03, 32'h0);
    rd(8'h10, 32'h0);
`ifdef PN_MON_IRQ_EN
    rd(8'h04, 32'h3);
`else
    rd(8'h04, 32'h0);
`endif

    // basic window: 10 errors on channel 2
    enable = '1;
    wr(8'h01, 100);
    wr(8'h00, 32'h1);
    rd(8'h02, 32'h1);
    cyc(5);
    pn_err = 4'b0100;
    cyc(10);
    pn_err = '0;
    cyc(120);
    rd(8'h02, 32'h2);
    rd(8'h10, 0); rd(8'h11, 0); rd(8'h12, 10); rd(8'h13, 0);
    wr(8'h02, 32'h2);
    rd(8'h02, 32'h0);

    // randomized windows against the counting model
    model_sticky = '0;
    for (int r = 0; r < 4; r++) begin
      wr(8'h00, 32'h2);
      model_sticky = '0;
      for (int i = 0; i < NCH; i++) model_cnt[i] = 0;
      wr(8'h01, 200);
      wr(8'h00, 32'h1);
      cyc(5);
      for (int c = 0; c < 60; c++) begin
        pn_err = NCH'($urandom);
        pn_oos = NCH'($urandom & $urandom);
        enable = NCH'($urandom | $urandom);
        for (int i = 0; i < NCH; i++)
          if (pn_err[i] && enable[i] && !pn_oos[i]) model_cnt[i]++;
        model_sticky |= pn_oos & enable;
        cyc(1);
      end
      pn_err = '0; pn_oos = '0; enable = '1;
      cyc(220);
      for (int i = 0; i < NCH; i++) rd(8'(16 + i), sat(model_cnt[i]));
      rd(8'h08, {28'd0, model_sticky});
      rd(8'h02, {29'd0, |model_sticky, 1'b1, 1'b0});
      wr(8'h02, 32'h2);
    end
    wr(8'h00, 32'h2);
    rd(8'h08, 32'h0);

    // saturation
    pn_err = 4'b0001;
    wr(8'h01, 300);
    wr(8'h00, 32'h1);
    cyc(350);
    pn_err = '0;
    rd(8'h10, 32'hFF);
    wr(8'h02, 32'h2);

    // OOS gating and sticky W1C
    wr(8'h00, 32'h2);
    pn_oos = 4'b0010; pn_err = 4'b0010;
    wr(8'h01, 20);
    wr(8'h00, 32'h1);
    cyc(40);
    rd(8'h11, 32'h0);
    rd(8'h08, 32'h2);
    pn_oos = '0; pn_err = '0;
    cyc(3);
    wr(8'h08, 32'h2);
    rd(8'h08, 32'h0);
    wr(8'h02, 32'h2);

    // CLEAR coinciding with the last increment, then START during RUN
    wr(8'h01, 300);
    pn_err = 4'b1000;
    wr(8'h00, 32'h1);
    cyc(20);
    @(posedge adc_clk); #1;
    up_wreq = 1'b1; up_waddr = 8'h00; up_wdata = 32'h2; pn_err = '0;
    @(posedge adc_clk); #1;
    up_wreq = 1'b0;
    rd(8'h13, 32'h0);
    rd(8'h02, 32'h1);
    cyc(30);
    wr(8'h00, 32'h1);
    rd(8'h03, 32'd300);
    cyc(280);
    rd(8'h02, 32'h1);
    cyc(40);
    rd(8'h02, 32'h2);
    wr(8'h02, 32'h2);

    // unmapped address
    @(posedge adc_clk); #1;
    up_rreq = 1'b1; up_raddr = 8'h05;
    @(posedge adc_clk); #1;
    up_rreq = 1'b0;
    chk("unmapped_rack", {31'd0, up_rack}, 32'd0);
    chk("unmapped_rdata", up_rdata, 32'd0);

    // interrupt
    wr(8'h04, 32'h0);
    wr(8'h01, 10);
    wr(8'h00, 32'h1);
    cyc(30);
`ifdef PN_MON_IRQ_EN
    chk("irq_done", {31'd0, irq}, 32'd1);
`else
    chk("irq_done", {31'd0, irq}, 32'd0);
`endif
    wr(8'h02, 32'h2);
    cyc(1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr(8'h04, 32'h3);

    // reset in the middle of a counting window
    pn_err = 4'b0001;
    wr(8'h01, 300);
    wr(8'h00, 32'h1);
    cyc(30);
    adc_rst = 1'b1;
    cyc(1);
    adc_rst = 1'b0;
    pn_err = '0;
    chk("irq_midrun_reset", {31'd0, irq}, 32'd0);
    rd(8'h02, 32'h0);
    rd(8'h10, 32'h0);
    rd(8'h03, 32'h0);
    rd(8'h01, 32'h0);

    cyc(5);
    chk("rd_queue_empty", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
